// File: rtl/flot_sqrt_pkg.sv
// Shared definitions for the float square-root operand path: class codes,
// default field widths and an exponent-field mask helper.
package flot_sqrt_pkg;

  localparam int FLT_WIDTH = 32;
  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAT_W = 23;

  typedef enum logic [1:0] {
    CLS_NORMAL  = 2'b00,
    CLS_ZERO    = 2'b01,
    CLS_NEG     = 2'b10,
    CLS_SPECIAL = 2'b11
  } cls_t;

  // Mask covering the exponent field in place (bits [mat_w+exp_w-1 : mat_w]).
  function automatic logic [63:0] exp_ones_mask(input int exp_w, input int mat_w);
    logic [63:0] m;
    m = ((64'd1 << exp_w) - 64'd1) << mat_w;
    return m;
  endfunction

endpackage

// File: rtl/flot_sync_fifo.sv
// Synchronous FIFO with occupancy count, full/empty flags and a synchronous
// flush that also swallows a same-cycle push.
module flot_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/flot_sqrt_operand_issue.sv
// Operand feeder for the float sqrt units: FIFO-buffers operands, classifies
// the head entry and issues a registered OP/CE/exce_in triple under hold.
// Optional issue statistics are enabled with FSQRT_ISSUE_STATS_EN.
module flot_sqrt_operand_issue
  import flot_sqrt_pkg::*;
#(
  parameter int WIDTH     = FLT_WIDTH,
  parameter int WIDTH_exp = FLT_EXP_W,
  parameter int WIDTH_mat = FLT_MAT_W,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op,
  input  logic             in_exce,
  input  logic             flush,
  input  logic             hold,
  output logic [WIDTH-1:0] OP,
  output logic             CE,
  output logic             exce_in,
  output logic [1:0]       cls,
  output logic [PTR_W:0]   occupancy
`ifdef FSQRT_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_exce
`endif
);

  localparam logic [WIDTH-1:0] EXP_MASK = WIDTH'(exp_ones_mask(WIDTH_exp, WIDTH_mat));

  logic [WIDTH:0]   w_head;
  logic [WIDTH-1:0] w_head_op;
  logic             w_head_exce;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [WIDTH-1:0] w_op;
  logic             w_exce;
  cls_t             w_cls;

  logic [WIDTH-1:0] r_op;
  logic             r_ce;
  logic             r_exce;
  cls_t             r_cls;

  // Handshake: a beat moves when in_valid && in_ready; in_ready is !full and
  // deliberately ignores a same-cycle pop so it never depends on hold/flush.
  assign in_ready = !w_full;
  assign w_pop    = !w_empty && !hold && !flush;

  flot_sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .flush (flush),
    .push  (in_valid),
    .pop   (w_pop),
    .wdata ({in_exce, in_op}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (occupancy)
  );

  assign w_head_op   = w_head[WIDTH-1:0];
  assign w_head_exce = w_head[WIDTH];

  // Priority: inf/NaN, then zero/denormal (flushed to signed zero), then negative.
  always_comb begin
    w_op   = w_head_op;
    w_exce = w_head_exce;
    w_cls  = CLS_NORMAL;
    if ((w_head_op & EXP_MASK) == EXP_MASK) begin
      w_cls  = CLS_SPECIAL;
      w_exce = 1'b1;
    end else if ((w_head_op & EXP_MASK) == '0) begin
      w_cls            = CLS_ZERO;
      w_op             = '0;
      w_op[WIDTH-1]    = w_head_op[WIDTH-1];
    end else if (w_head_op[WIDTH-1]) begin
      w_cls  = CLS_NEG;
      w_exce = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op   <= '0;
      r_ce   <= 1'b0;
      r_exce <= 1'b0;
      r_cls  <= CLS_NORMAL;
    end else begin
      r_ce <= w_pop;
      if (w_pop) begin
        r_op   <= w_op;
        r_exce <= w_exce;
        r_cls  <= w_cls;
      end
    end
  end

  assign OP      = r_op;
  assign CE      = r_ce;
  assign exce_in = r_exce;
  assign cls     = r_cls;

`ifdef FSQRT_ISSUE_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_exce;

  // Saturating counters; only RST clears them, flush leaves history intact.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_issued <= '0;
      r_stat_exce   <= '0;
    end else if (r_ce) begin
      if (r_stat_issued != 16'hFFFF) r_stat_issued <= r_stat_issued + 16'd1;
      if (r_exce && (r_stat_exce != 16'hFFFF)) r_stat_exce <= r_stat_exce + 16'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_exce   = r_stat_exce;
`endif

endmodule

// File: tb/tb_flot_sqrt_operand_issue.sv
// Directed bench for flot_sqrt_operand_issue with an expected-result queue
// filled at push time and drained as CE pulses appear.
module tb_flot_sqrt_operand_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op;
  logic        in_exce;
  logic        flush;
  logic        hold;
  logic [31:0] OP;
  logic        CE;
  logic        exce_in;
  logic [1:0]  cls;
  logic [2:0]  occupancy;
`ifdef FSQRT_ISSUE_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_exce;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [34:0] exp_q[$];

  flot_sqrt_operand_issue dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_exce   (in_exce),
    .flush     (flush),
    .hold      (hold),
    .OP        (OP),
    .CE        (CE),
    .exce_in   (exce_in),
    .cls       (cls),
    .occupancy (occupancy)
`ifdef FSQRT_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_exce   (stat_exce)
`endif
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Reference classification: {exce_in, cls, OP}
  function automatic logic [34:0] model(input logic [31:0] op, input logic ex);
    logic [7:0] e;
    e = op[30:23];
    if (e == 8'hFF)      return {1'b1, 2'b11, op};
    else if (e == 8'h00) return {ex, 2'b01, op[31], 31'b0};
    else if (op[31])     return {1'b1, 2'b10, op};
    else                 return {ex, 2'b00, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every CE must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    logic [34:0] e;
    if (CE === 1'b1) begin
      check("ce_expected", 64'(CE), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("issue", 64'({exce_in, cls, OP}), 64'(e));
      end
    end
  end

  // Drivers
  task automatic push_beat(input logic [31:0] op, input logic ex);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_exce  = ex;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (waited >= 20) begin
      check("push_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back(model(op, ex));
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(posedge CLK); #1;
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_op = '0; in_exce = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ce", 64'(CE), 64'd0);
    check("rst_op", 64'(OP), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Latency: push at N, CE at N+2
    in_valid = 1'b1; in_op = 32'h3FE00000; in_exce = 1'b0;
    exp_q.push_back(model(32'h3FE00000, 1'b0));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("lat_ce_n1", 64'(CE), 64'd0);
    check("lat_occ_n1", 64'(occupancy), 64'd1);
    @(negedge CLK);
    check("lat_ce_n2", 64'(CE), 64'd1);
    wait_drain();

    // Classification patterns, back-to-back
    push_beat(32'hC3E00000, 1'b0);
    push_beat(32'h80000000, 1'b0);
    push_beat(32'h00012345, 1'b0);
    push_beat(32'h7F800000, 1'b0);
    push_beat(32'h40000000, 1'b1);
    push_beat(32'h7FC00001, 1'b0);
    push_beat(32'h00000000, 1'b1);
    wait_drain();

    // Full / hold, then back-to-back drain
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push_beat(32'h3F800000 + 32'(i), 1'b0);
    @(negedge CLK);
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    hold = 1'b0; in_valid = 1'b1; in_op = 32'h3F800004; in_exce = 1'b0;
    check("no_lookahead", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    check("b2b_ce0", 64'(CE), 64'd1);
    check("ready_after_pop", 64'(in_ready), 64'd1);
    exp_q.push_back(model(32'h3F800004, 1'b0));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("b2b_ce1", 64'(CE), 64'd1);
    for (int i = 2; i < 5; i++) begin
      @(posedge CLK); #1;
      check("b2b_ce", 64'(CE), 64'd1);
    end
    wait_drain();

    // Flush with a simultaneous push
    hold = 1'b1;
    push_beat(32'h41000000, 1'b0);
    push_beat(32'h41100000, 1'b0);
    push_beat(32'h41200000, 1'b0);
    @(negedge CLK);
    check("pre_flush_occ", 64'(occupancy), 64'd3);
    @(posedge CLK); #1;
    flush = 1'b1; in_valid = 1'b1; in_op = 32'h42000000;
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
    exp_q.delete();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_ce", 64'(CE), 64'd0);
    repeat (5) @(posedge CLK);
    #1;
    check("post_flush_occ", 64'(occupancy), 64'd0);

    // Reset mid-stream
    hold = 1'b1;
    push_beat(32'h43000000, 1'b0);
    push_beat(32'h43100000, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; hold = 1'b0;
    exp_q.delete();
    check("mid_rst_ce", 64'(CE), 64'd0);
    check("mid_rst_op", 64'(OP), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge CLK);
    #1;
    check("post_rst_occ", 64'(occupancy), 64'd0);

    // Random normals after reset
    for (int i = 0; i < 6; i++) begin
      push_beat({1'b0, 8'($urandom_range(1, 254)), 23'($urandom_range(0, 32'h7FFFFF))},
                1'($urandom_range(0, 1)));
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
